// File: rtl/gesture_pkg.sv
// Purpose: shared constants, cell record type, controller states and the
//          shift-linear decay function for the time-surface store.
// Contents:
//   GRID_SIZE, VALUE_BITS, TS_BITS, DECAY_SHIFT, NUM_CELLS, derived widths
//   cell_t  : {valid, stamp} as held in each RAM word
//   state_t : clear-sweep controller states
//   decay() : age -> decayed value
package gesture_pkg;

  localparam int GRID_SIZE   = 16;
  localparam int VALUE_BITS  = 8;
  localparam int TS_BITS     = 16;
  localparam int DECAY_SHIFT = 4;
  localparam int NUM_CELLS   = GRID_SIZE * GRID_SIZE;
  localparam int XY_BITS     = $clog2(GRID_SIZE);
  localparam int ADDR_BITS   = $clog2(NUM_CELLS);
  localparam int DROP_BITS   = 16;

  typedef struct packed {
    logic               valid;
    logic [TS_BITS-1:0] stamp;
  } cell_t;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  // Value falls by one every 2^DECAY_SHIFT ticks from full scale; invalid
  // or fully-decayed cells read zero. The subtraction wraps, so the age is
  // correct across a wrap of the time counter.
  function automatic logic [VALUE_BITS-1:0] decay(input cell_t c,
                                                  input logic [TS_BITS-1:0] now);
    logic [TS_BITS-1:0] age;
    logic [TS_BITS-1:0] q;
    age = now - c.stamp;
    q   = age >> DECAY_SHIFT;
    if (!c.valid || q >= TS_BITS'((2 ** VALUE_BITS) - 1))
      return '0;
    else
      return {VALUE_BITS{1'b1}} - q[VALUE_BITS-1:0];
  endfunction

endpackage

// File: rtl/time_surface_store_if.sv
// Purpose: event-write and time-surface-read buses of the store.
// Signals:
//   ev_valid, ev_x, ev_y : event strobe and cell coordinates (binner -> store)
//   ev_ready             : store accepts events (low while clearing)
//   ts_addr, ts_en       : read request (consumer -> store)
//   ts_val               : decayed value, two cycles after the request
// Modports: master = binner/consumer side, slave = store side.
interface time_surface_store_if;
  import gesture_pkg::*;

  logic                  ev_valid;
  logic [XY_BITS-1:0]    ev_x;
  logic [XY_BITS-1:0]    ev_y;
  logic                  ev_ready;
  logic [ADDR_BITS-1:0]  ts_addr;
  logic                  ts_en;
  logic [VALUE_BITS-1:0] ts_val;

  modport master (
    output ev_valid, ev_x, ev_y, ts_addr, ts_en,
    input  ev_ready, ts_val
  );

  modport slave (
    input  ev_valid, ev_x, ev_y, ts_addr, ts_en,
    output ev_ready, ts_val
  );

endinterface

// File: rtl/ts_stamp_ram.sv
// Purpose: NUM_CELLS x cell_t simple dual-port RAM, one write port and one
//          read port, read-first, registered (1-cycle) read output.
// Ports:
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request
//   rdata        : contents of raddr one cycle after re (old data on collision)
module ts_stamp_ram
  import gesture_pkg::*;
(
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  cell_t                wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output cell_t                rdata
);

  cell_t mem [NUM_CELLS];

  // NOTE: the array and its output register have no reset so the tools can
  // map them onto block RAM; the clear sweep initialises the contents.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    // Both updates are scheduled at the edge, so a same-address read sees
    // the word as it was before this cycle's write.
    if (re)
      rdata <= mem[raddr];
  end

endmodule

// File: rtl/time_surface_store.sv
// Purpose: per-cell event timestamp store for a GRID_SIZE x GRID_SIZE grid,
//          serving decayed time-surface values to scanning consumers.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset; starts a clear sweep
//   tick       : time-base pulse, advances the global time counter
//   clear      : pulse, invalidates all cells (restarts a running sweep)
//   clear_busy : clear sweep in progress (exactly NUM_CELLS cycles)
//   drop_cnt   : saturating count of events that were not stored
//   bus        : event-write and read buses (slave side)
module time_surface_store
  import gesture_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 clear,
  output logic                 clear_busy,
  output logic [DROP_BITS-1:0] drop_cnt,
  time_surface_store_if.slave  bus
);

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] clr_addr, clr_addr_next;
  logic [TS_BITS-1:0]   now;
  logic                 en_d1;
  logic                 ev_accept;
  logic                 ev_drop;
  logic                 we;
  logic [ADDR_BITS-1:0] waddr;
  cell_t                wdata;
  cell_t                rd_cell;

  // Clear-sweep controller.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    if (clear) begin
      state_next    = S_CLEAR;
      clr_addr_next = '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_addr_next = clr_addr + 1'b1;
          if (clr_addr == ADDR_BITS'(NUM_CELLS - 1))
            state_next = S_RUN;
        end
        S_RUN:   state_next = S_RUN;
        default: state_next = S_CLEAR;
      endcase
    end
  end

  assign clear_busy   = (state == S_CLEAR);
  assign bus.ev_ready = !clear_busy;

  // A clear pulse wins over an event arriving in the same cycle.
  assign ev_accept = bus.ev_valid && bus.ev_ready && !clear;
  assign ev_drop   = bus.ev_valid && !ev_accept;

  // Write mux: the sweep owns the write port while busy.
  always_comb begin
    we    = 1'b0;
    waddr = {bus.ev_y, bus.ev_x};
    wdata = '{valid: 1'b1, stamp: now};
    if (clear_busy) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = '0;
    end else if (ev_accept) begin
      we = 1'b1;
    end
  end

  // NOTE: non-blocking assignment means a same-cycle event stamps the
  // pre-increment value of now, which is the intended behaviour.
  always_ff @(posedge clk) begin
    if (rst)
      now <= '0;
    else if (tick)
      now <= now + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (ev_drop && drop_cnt != '1)
      drop_cnt <= drop_cnt + 1'b1;
  end

  ts_stamp_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (bus.ts_en),
    .raddr (bus.ts_addr),
    .rdata (rd_cell)
  );

  // S1 is the RAM output register; en_d1 tracks which cycles carry a result.
  // S2 applies decay against the current time, or forces zero while the
  // surface is being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_d1      <= 1'b0;
      bus.ts_val <= '0;
    end else begin
      en_d1 <= bus.ts_en;
      if (en_d1)
        bus.ts_val <= clear_busy ? '0 : decay(rd_cell, now);
    end
  end

endmodule

// File: tb/tb_time_surface_store.sv
// Self-checking bench for time_surface_store: table-driven decay vectors
// plus directed sequences for sweep timing, drops, collision and bursts.
module tb_time_surface_store;
  import gesture_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tick;
  logic                 clear;
  logic                 clear_busy;
  logic [DROP_BITS-1:0] drop_cnt;

  time_surface_store_if bus ();

  time_surface_store dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .clear      (clear),
    .clear_busy (clear_busy),
    .drop_cnt   (drop_cnt),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [XY_BITS-1:0]    x;
    logic [XY_BITS-1:0]    y;
    logic                  write;
    int                    age;
    logic [VALUE_BITS-1:0] exp;
  } vec_t;

  vec_t                  vecs [10];
  logic [VALUE_BITS-1:0] exp_mem [NUM_CELLS];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic send_event(input logic [XY_BITS-1:0] x, input logic [XY_BITS-1:0] y);
    bus.ev_valid = 1'b1;
    bus.ev_x     = x;
    bus.ev_y     = y;
    step();
    bus.ev_valid = 1'b0;
  endtask

  task automatic read_cell(input logic [ADDR_BITS-1:0] addr, output int val);
    bus.ts_en   = 1'b1;
    bus.ts_addr = addr;
    step();
    bus.ts_en = 1'b0;
    step();
    val = int'(bus.ts_val);
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (clear_busy && n < 1000) begin
      step();
      n++;
    end
    check("sweep_ends", int'(clear_busy), 0);
  endtask

  // Reads every cell back-to-back; result for issue k appears after step k+2.
  task automatic burst_read(input string name);
    bus.ts_en   = 1'b1;
    bus.ts_addr = '0;
    for (int k = 1; k <= NUM_CELLS + 1; k++) begin
      step();
      if (k < NUM_CELLS) bus.ts_addr = ADDR_BITS'(k);
      else               bus.ts_en   = 1'b0;
      if (k >= 2) check(name, int'(bus.ts_val), int'(exp_mem[k-2]));
    end
  endtask

  initial begin
    int n;
    int v;

    vecs[0] = '{x: 4'd1,  y: 4'd1, write: 1'b1, age: 0,    exp: 8'd255};
    vecs[1] = '{x: 4'd2,  y: 4'd1, write: 1'b1, age: 15,   exp: 8'd255};
    vecs[2] = '{x: 4'd3,  y: 4'd1, write: 1'b1, age: 16,   exp: 8'd254};
    vecs[3] = '{x: 4'd4,  y: 4'd1, write: 1'b1, age: 32,   exp: 8'd253};
    vecs[4] = '{x: 4'd5,  y: 4'd1, write: 1'b1, age: 255,  exp: 8'd240};
    vecs[5] = '{x: 4'd6,  y: 4'd1, write: 1'b1, age: 1000, exp: 8'd193};
    vecs[6] = '{x: 4'd7,  y: 4'd1, write: 1'b1, age: 4079, exp: 8'd1};
    vecs[7] = '{x: 4'd8,  y: 4'd1, write: 1'b1, age: 4080, exp: 8'd0};
    vecs[8] = '{x: 4'd9,  y: 4'd1, write: 1'b1, age: 4095, exp: 8'd0};
    vecs[9] = '{x: 4'd10, y: 4'd1, write: 1'b0, age: 100,  exp: 8'd0};

    rst          = 1'b1;
    tick         = 1'b0;
    clear        = 1'b0;
    bus.ev_valid = 1'b0;
    bus.ev_x     = '0;
    bus.ev_y     = '0;
    bus.ts_en    = 1'b0;
    bus.ts_addr  = '0;

    // Reset state and automatic sweep length.
    repeat (3) step();
    check("reset_ts_val", int'(bus.ts_val), 0);
    check("reset_drop_cnt", int'(drop_cnt), 0);
    check("reset_ev_ready", int'(bus.ev_ready), 0);
    check("reset_clear_busy", int'(clear_busy), 1);
    rst = 1'b0;
    wait_sweep(n);
    check("reset_sweep_cycles", n, 256);
    check("ev_ready_after_sweep", int'(bus.ev_ready), 1);

    for (int i = 0; i < NUM_CELLS; i++) exp_mem[i] = '0;
    burst_read("cleared_cell");

    // Event (3,2) at now=100, read at now=100 and now=132; output holds.
    tick_n(100);
    send_event(4'd3, 4'd2);
    read_cell(8'd35, v);
    check("fresh_cell35", v, 255);
    repeat (3) step();
    check("ts_val_holds", int'(bus.ts_val), 255);
    tick_n(32);
    read_cell(8'd35, v);
    check("aged32_cell35", v, 253);

    // Decay table.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].write) send_event(vecs[i].x, vecs[i].y);
      if (vecs[i].age > 0) tick_n(vecs[i].age);
      read_cell({vecs[i].y, vecs[i].x}, v);
      check($sformatf("decay_vec%0d", i), v, int'(vecs[i].exp));
    end

    // Event and tick in the same cycle stamps the pre-increment time.
    tick         = 1'b1;
    bus.ev_valid = 1'b1;
    bus.ev_x     = 4'd0;
    bus.ev_y     = 4'd3;
    step();
    bus.ev_valid = 1'b0;
    repeat (15) step();
    tick = 1'b0;
    read_cell(8'd48, v);
    check("tick_same_cycle_stamp", v, 254);

    // Clear and event together: clear wins, event dropped.
    check("drop_cnt_before_clear", int'(drop_cnt), 0);
    clear        = 1'b1;
    bus.ev_valid = 1'b1;
    bus.ev_x     = 4'd5;
    bus.ev_y     = 4'd5;
    step();
    clear        = 1'b0;
    bus.ev_valid = 1'b0;
    check("drop_on_clear", int'(drop_cnt), 1);
    check("busy_after_clear", int'(clear_busy), 1);
    check("ev_ready_in_sweep", int'(bus.ev_ready), 0);
    // Cell 35 is not yet swept here but must read zero while busy.
    read_cell(8'd35, v);
    check("read_forced_zero_busy", v, 0);
    send_event(4'd1, 4'd1);
    check("drop_in_sweep", int'(drop_cnt), 2);
    wait_sweep(n);
    check("clear_sweep_cycles", n + 3, 256);
    read_cell(8'd85, v);
    check("clear_wins_cell85", v, 0);
    read_cell(8'd35, v);
    check("cleared_cell35", v, 0);

    // Same-cycle write and read of addr 7 returns the old (invalid) word.
    bus.ev_valid = 1'b1;
    bus.ev_x     = 4'd7;
    bus.ev_y     = 4'd0;
    bus.ts_en    = 1'b1;
    bus.ts_addr  = 8'd7;
    step();
    bus.ev_valid = 1'b0;
    bus.ts_en    = 1'b0;
    step();
    check("collision_read_first", int'(bus.ts_val), 0);
    read_cell(8'd7, v);
    check("after_collision_cell7", v, 255);

    // Full-throughput burst over a known surface.
    send_event(4'd3, 4'd2);
    for (int i = 0; i < NUM_CELLS; i++) exp_mem[i] = '0;
    exp_mem[7]  = 8'd255;
    exp_mem[35] = 8'd255;
    burst_read("burst_cell");

    // Reset in the middle of a read flushes the pipeline and restarts sweep.
    bus.ts_en   = 1'b1;
    bus.ts_addr = 8'd7;
    step();
    bus.ts_en = 1'b0;
    rst       = 1'b1;
    step();
    check("midread_reset_ts_val", int'(bus.ts_val), 0);
    check("midread_reset_busy", int'(clear_busy), 1);
    check("midread_reset_drop", int'(drop_cnt), 0);
    rst = 1'b0;
    wait_sweep(n);
    check("midread_reset_sweep", n, 256);
    check("after_reset_ts_val", int'(bus.ts_val), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
